// File: rtl/pipe_sequencer.sv
// pipe_sequencer: pipeline control sequencer for a five-stage in-order core.
// Resolves load-use stalls, taken-branch flushes, memory freezes and the HLT
// drain/stop sequence, and keeps saturating stall/flush performance counters.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   hazard_stall             load-use hazard for the instruction in ID
//   branch_taken             branch in ID resolved taken
//   id_hlt / wb_hlt          HLT present in ID / HLT reached WB
//   dmem_busy                data memory not ready, freeze everything
//   pc_we, if_id_we          front-end write enables
//   if_id_flush              IF/ID loads a NOP
//   id_ex_bubble             ID/EX loads zeroed controls
//   back_we                  shared enable for ID/EX, EX/MEM, MEM/WB
//   halted, state            processor stopped / FSM state (RUN=0, DRAIN=1, HALTED=2)
//   stall_cnt, flush_cnt     saturating performance counters
module pipe_sequencer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_stall,
  input  logic             branch_taken,
  input  logic             id_hlt,
  input  logic             wb_hlt,
  input  logic             dmem_busy,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             back_we,
  output logic             halted,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    HALTED  = 2'd2,
    ILLEGAL = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic             stall_prev_q, stall_prev_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             eff_stall;

  // Next-state, counter updates and combinational control outputs
  always_comb begin
    state_d      = state_q;
    stall_prev_d = stall_prev_q;
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    pc_we        = 1'b0;
    if_id_we     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    back_we      = 1'b0;
    halted       = 1'b0;

    // A stall is never taken two cycles running; only meaningful in RUN
    eff_stall = (state_q == RUN) & hazard_stall & ~stall_prev_q & ~dmem_busy;

    // stall_prev freezes with the rest of the pipe while memory is busy
    if (!dmem_busy) begin
      stall_prev_d = eff_stall;
    end

    case (state_q)
      RUN: begin
        if (dmem_busy) begin
          // full freeze: every enable stays low
        end else if (eff_stall) begin
          id_ex_bubble = 1'b1;
          back_we      = 1'b1;
          stall_cnt_d  = (stall_cnt_q == CNT_MAX) ? stall_cnt_q : stall_cnt_q + CNT_W'(1);
        end else if (id_hlt) begin
          // HLT beats a same-cycle taken branch; that flush is not counted
          if_id_we    = 1'b1;
          if_id_flush = 1'b1;
          back_we     = 1'b1;
          state_d     = DRAIN;
        end else if (branch_taken) begin
          pc_we       = 1'b1;
          if_id_we    = 1'b1;
          if_id_flush = 1'b1;
          back_we     = 1'b1;
          flush_cnt_d = (flush_cnt_q == CNT_MAX) ? flush_cnt_q : flush_cnt_q + CNT_W'(1);
        end else begin
          pc_we    = 1'b1;
          if_id_we = 1'b1;
          back_we  = 1'b1;
        end
      end
      DRAIN: begin
        // keep feeding NOPs behind the HLT until it retires
        if_id_we    = 1'b1;
        if_id_flush = 1'b1;
        back_we     = ~dmem_busy;
        if (wb_hlt && !dmem_busy) begin
          state_d = HALTED;
        end
      end
      HALTED: begin
        halted = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    // Reset forces the free-running enable pattern regardless of inputs
    if (rst) begin
      pc_we        = 1'b1;
      if_id_we     = 1'b1;
      back_we      = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      halted       = 1'b0;
    end
  end

  // State and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RUN;
      stall_prev_q <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      stall_prev_q <= stall_prev_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign state     = state_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
